// File: rtl/des_key_schedule_if.sv
// Handshake and data bundle between a DES key-schedule generator and its
// producer (key load) and consumer (round datapath).
interface des_key_schedule_if;
  logic [63:0] key_in;
  logic        decrypt;
  logic        start;
  logic        busy;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        done;
  logic        parity_err;

  modport master (
    output key_in, decrypt, start, subkey_ready,
    input  busy, subkey_valid, subkey, round_idx, done, parity_err
  );

  modport slave (
    input  key_in, decrypt, start, subkey_ready,
    output busy, subkey_valid, subkey, round_idx, done, parity_err
  );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 once at start, then one PC-2 subkey per
// valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule #(
  parameter logic [15:0] SHIFT_MASK   = 16'h8103,
  parameter bit          PARITY_CHECK = 1'b0
) (
  input logic           clk,
  input logic           rst,
  des_key_schedule_if.slave kif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Tables hold FIPS 46-3 bit numbers (1 = leftmost / MSB).
  localparam logic [6:0] PC1_TAB [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50,
    7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35,
    7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36, 7'd63, 7'd55,
    7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38,
    7'd30, 7'd22, 7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21,
    7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,
    6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,
    6'd27, 6'd20, 6'd13, 6'd2,  6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = 56'h0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(7'd64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = 48'h0;
    for (int j = 0; j < 48; j++) begin
      r[6'(47 - j)] = cd[6'(6'd56 - PC2_TAB[j])];
    end
    return r;
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^k[b*8 +: 8]);
    end
    return ok;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by_two);
    return by_two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by_two);
    return by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        perr_q, perr_d;

  logic [55:0] pc1_s;
  logic        hs_s;
  logic        two_first_s, two_enc_s, two_dec_s;

  // A clear mask bit means that round shifts by two.
  assign pc1_s       = pc1(kif.key_in);
  assign hs_s        = (state_q == RUN) && kif.subkey_ready;
  assign two_first_s = ~SHIFT_MASK[0];
  assign two_enc_s   = ~SHIFT_MASK[cnt_q + 4'd1];
  assign two_dec_s   = ~SHIFT_MASK[cnt_q];

  // Next-state, C/D rotation and completion logic.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          if ((PARITY_CHECK == 1'b1) && !key_parity_ok(kif.key_in)) begin
            done_d = 1'b1;
            perr_d = 1'b1;
          end else begin
            mode_d  = kif.decrypt;
            perr_d  = 1'b0;
            state_d = RUN;
            if (kif.decrypt) begin
              c_d   = pc1_s[55:28];
              d_d   = pc1_s[27:0];
              cnt_d = 4'd15;
            end else begin
              c_d   = rotl28(pc1_s[55:28], two_first_s);
              d_d   = rotl28(pc1_s[27:0], two_first_s);
              cnt_d = 4'd0;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (hs_s) begin
          if (mode_q) begin
            c_d   = rotr28(c_q, two_dec_s);
            d_d   = rotr28(d_q, two_dec_s);
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            c_d   = rotl28(c_q, two_enc_s);
            d_d   = rotl28(d_q, two_enc_s);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= 28'h0;
      d_q     <= 28'h0;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign kif.busy         = (state_q == RUN);
  assign kif.subkey_valid = (state_q == RUN);
  assign kif.subkey       = pc2({c_q, d_q});
  assign kif.round_idx    = cnt_q;
  assign kif.done         = done_q;
  assign kif.parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: a cumulative-shift reference model
// feeds expected subkeys into queues that a negedge monitor drains.
module tb_des_key_schedule;

  localparam logic [15:0] MASK = 16'h8103;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35,
    27, 19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38,
    30, 22, 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7,
    27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56,
    34, 53, 46, 42, 50, 36, 29, 32};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sk_q [$];
  logic dn_q [$];
  logic [47:0] mk [16];

  des_key_schedule_if ifc ();

  des_key_schedule #(.SHIFT_MASK(16'h8103), .PARITY_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .kif (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: each round's C/D is C0/D0 rotated left by the running shift total.
  task automatic model(input logic [63:0] k);
    logic [55:0] cd;
    int cum, p, src;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1[6'(i)])];
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum += MASK[4'(r)] ? 1 : 2;
      for (int j = 0; j < 48; j++) begin
        p = PC2[6'(j)];
        if (p <= 28) src = (p - 1 + cum) % 28;
        else         src = 28 + (p - 29 + cum) % 28;
        mk[4'(r)][6'(47 - j)] = cd[6'(55 - src)];
      end
    end
  endtask

  function automatic bit par_ok(input logic [63:0] k);
    bit ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      logic [7:0] by = 8'(k >> (8 * b));
      if ($countones(by) % 2 == 0) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] r = k;
    for (int b = 0; b < 8; b++) begin
      logic [7:0] by = 8'(r >> (8 * b));
      if ($countones(by) % 2 == 0) r = r ^ (64'h1 << (8 * b));
    end
    return r;
  endfunction

  // Monitor: compare every presented subkey and done pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.subkey_valid) begin
        if (sk_q.size() == 0) begin
          check(1'b0, "unexpected_subkey", {12'h0, ifc.round_idx, ifc.subkey}, 64'h0);
        end else begin
          check(ifc.subkey === sk_q[0].sk && ifc.round_idx === sk_q[0].idx, "subkey",
                {12'h0, ifc.round_idx, ifc.subkey}, {12'h0, sk_q[0].idx, sk_q[0].sk});
          if (ifc.subkey_ready) void'(sk_q.pop_front());
        end
      end
      if (ifc.done) begin
        if (dn_q.size() == 0) begin
          check(1'b0, "unexpected_done", {63'h0, ifc.parity_err}, 64'h0);
        end else begin
          check(ifc.parity_err === dn_q[0], "parity_err", {63'h0, ifc.parity_err}, {63'h0, dn_q[0]});
          void'(dn_q.pop_front());
        end
      end
    end
  end

  task automatic do_start(input logic [63:0] k, input logic dec);
    ifc.key_in  = k;
    ifc.decrypt = dec;
    ifc.start   = 1'b1;
    if (!par_ok(k)) begin
      dn_q.push_back(1'b1);
    end else begin
      model(k);
      for (int r = 0; r < 16; r++) begin
        int ri = dec ? 15 - r : r;
        sk_q.push_back('{sk: mk[4'(ri)], idx: 4'(ri)});
      end
      dn_q.push_back(1'b0);
    end
    @(posedge clk); #1;
    ifc.start   = 1'b0;
    ifc.key_in  = {$urandom(), $urandom()};
    ifc.decrypt = ~dec;
  endtask

  // Drives ready from T+1 and checks busy/valid/done timing cycle by cycle.
  task automatic run_body(input bit abort, input int stall_idx, input int stall_len,
                          input int rst_idx, input bit rand_ready, input int start_idx);
    int  h = 0;
    int  need = abort ? 0 : 16;
    int  stalled = 0;
    bit  poked = 1'b0;
    logic rdy;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (h == need) begin
        @(negedge clk);
        check(ifc.done === 1'b1 && ifc.busy === 1'b0 && ifc.subkey_valid === 1'b0, "done_timing",
              {61'h0, ifc.busy, ifc.subkey_valid, ifc.done}, 64'd1);
        return;
      end
      rdy = 1'b1;
      if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
      if (h == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      ifc.subkey_ready = rdy;
      ifc.start = 1'b0;
      if (h == start_idx && !poked) begin
        ifc.start = 1'b1;
        poked = 1'b1;
      end
      if (h == rst_idx) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sk_q.delete();
        dn_q.delete();
        @(negedge clk);
        check(ifc.busy === 1'b0 && ifc.subkey_valid === 1'b0 && ifc.done === 1'b0 && ifc.subkey === 48'h0,
              "mid_reset", {13'h0, ifc.busy, ifc.subkey_valid, ifc.done, ifc.subkey}, 64'h0);
        for (int q = 0; q < 3; q++) begin
          @(negedge clk);
          check(ifc.done === 1'b0 && ifc.subkey_valid === 1'b0, "no_done_after_reset",
                {62'h0, ifc.done, ifc.subkey_valid}, 64'h0);
        end
        return;
      end
      @(negedge clk);
      check(ifc.busy === 1'b1 && ifc.subkey_valid === 1'b1 && ifc.done === 1'b0, "run_flags",
            {61'h0, ifc.busy, ifc.subkey_valid, ifc.done}, 64'd6);
      if (rdy) h++;
      @(posedge clk); #1;
    end
    check(1'b0, "timeout", 64'(h), 64'(need));
  endtask

  initial begin
    logic [63:0] k;
    ifc.key_in = 64'h0;
    ifc.decrypt = 1'b0;
    ifc.start = 1'b0;
    ifc.subkey_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check({ifc.busy, ifc.subkey_valid, ifc.done, ifc.parity_err, ifc.round_idx, ifc.subkey} === 56'h0,
          "reset_state", {8'h0, ifc.busy, ifc.subkey_valid, ifc.done, ifc.parity_err, ifc.round_idx, ifc.subkey}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    model(64'h133457799BBCDFF1);
    check(mk[0] === 48'h1B02EFFC7072, "kat_k1", {16'h0, mk[0]}, 64'h1B02EFFC7072);
    check(mk[1] === 48'h79AED9DBC9E5, "kat_k2", {16'h0, mk[1]}, 64'h79AED9DBC9E5);
    check(mk[15] === 48'hCB3D8B0E17F5, "kat_k16", {16'h0, mk[15]}, 64'hCB3D8B0E17F5);

    // Encrypt vector with a stray start mid-run, then decrypt order.
    do_start(64'h133457799BBCDFF1, 1'b0);
    run_body(1'b0, -1, 0, -1, 1'b0, 5);
    @(posedge clk); #1;
    do_start(64'h133457799BBCDFF1, 1'b1);
    run_body(1'b0, -1, 0, -1, 1'b0, -1);
    @(posedge clk); #1;

    // Backpressure: ready low for three cycles while idx 1 is presented.
    do_start(64'h133457799BBCDFF1, 1'b0);
    run_body(1'b0, 1, 3, -1, 1'b0, -1);
    @(posedge clk); #1;

    // Parity abort, parity_err holding, then a good key runs normally.
    do_start(64'h133457799BBCDFF0, 1'b0);
    run_body(1'b1, -1, 0, -1, 1'b0, -1);
    @(posedge clk); #1;
    @(negedge clk);
    check(ifc.parity_err === 1'b1 && ifc.done === 1'b0 && ifc.busy === 1'b0, "parity_hold",
          {61'h0, ifc.parity_err, ifc.done, ifc.busy}, 64'd4);
    @(posedge clk); #1;
    do_start(64'h133457799BBCDFF1, 1'b0);
    run_body(1'b0, -1, 0, -1, 1'b0, -1);
    @(posedge clk); #1;

    // Reset at idx 7.
    do_start(64'h133457799BBCDFF1, 1'b0);
    run_body(1'b0, -1, 0, 7, 1'b0, -1);
    @(posedge clk); #1;

    // Back-to-back: the next start lands in the done cycle.
    do_start(64'h0E329232EA6D0D73, 1'b0);
    run_body(1'b0, -1, 0, -1, 1'b0, -1);
    do_start(fix_parity({$urandom(), $urandom()}), 1'b1);
    run_body(1'b0, -1, 0, -1, 1'b0, -1);

    // Random keys, directions and ready patterns; some keys with a flipped bit.
    for (int t = 0; t < 24; t++) begin
      bit bad;
      k = fix_parity({$urandom(), $urandom()});
      bad = ($urandom_range(0, 4) == 0);
      if (bad) k = k ^ (64'h1 << $urandom_range(0, 63));
      do_start(k, 1'($urandom_range(0, 1)));
      run_body(bad, -1, 0, -1, 1'b1, -1);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    ifc.subkey_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(sk_q.size() == 0 && dn_q.size() == 0, "queues_drained",
          64'(sk_q.size() + dn_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator: applies PC-1 to a 64-bit key once, then produces the 16 48-bit round subkeys one per handshake through a valid/ready interface. The C/D halves are rotated per round and PC-2 is applied to them. It supports encrypt order (K1→K16, left rotations) and decrypt order (K16→K1, right rotations), with optional per-byte odd-parity checking. It sits between key load and the round datapath of the DES core and replaces the bare PC-1 permutation stage there.

## Interface
- SHIFT_MASK, 16'h8103: bit r-1 set means round r rotates by 1, clear means by 2 (standard DES: rounds 1, 2, 9, 16). Sum of shifts must equal 28.
- PARITY_CHECK, 0: 1 enables the odd-parity check on each key byte at start.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_in  in  64  DES key. DES bit n (1 = leftmost) is key_in[64-n]. Parity bits are DES bits 8, 16, …, 64.
- decrypt  in  1  sampled with start; 1 selects reverse subkey order.
- start  in  1  one-cycle request; accepted only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- subkey_valid  out  1  subkey/round_idx are valid.
- subkey_ready  in  1  downstream accepts the subkey on valid && ready.
- subkey  out  48  PC-2 output. DES bit n of the subkey is subkey[48-n].
- round_idx  out  4  round number minus 1 of the presented subkey.
- done  out  1  one-cycle pulse at the end of a schedule or a parity abort.
- parity_err  out  1  valid with done; 1 means the schedule was aborted on parity.

## Operation
- States: IDLE, RUN.
- Reset: state=IDLE, C=D=0, round counter 0, mode 0. All outputs 0.
- IDLE + start, with PARITY_CHECK=1 and any key byte having even parity:
  - Stay in IDLE.
  - Next cycle: done=1, parity_err=1. No subkeys are emitted.
- IDLE + start, otherwise:
  - Latch decrypt.
  - Load C‖D = PC-1(key_in), using the FIPS 46-3 table.
  - Encrypt: load rotl(C,s1), rotl(D,s1) instead.
  - round counter = 0 (encrypt) or 15 (decrypt). Go to RUN.
- RUN:
  - subkey_valid=1; subkey = PC-2(C‖D), taken directly from the registers with no combinational input path; round_idx = counter.
  - On a handshake in encrypt mode: counter+1; C,D rotate left by s(counter+2).
  - On a handshake in decrypt mode: C,D rotate right by s(counter+1); counter−1.
  - Rotations are 28-bit circular, independent per half.
  - Without a handshake, subkey, round_idx and C/D hold stable.
  - A handshake on round_idx 15 (encrypt) or 0 (decrypt) returns to IDLE, with done=1, parity_err=0 in the next cycle.
- start during RUN is ignored, and so is a change of decrypt.
- start in the same cycle as done is accepted, because the block is already in IDLE.
- rst mid-schedule: abort immediately to the reset state; no done pulse.
- parity_err holds its value until the next start is accepted.

## Timing
- start at cycle T is accepted: busy=1 and subkey_valid=1 from T+1, with the first subkey on T+1.
- With ready held high, subkeys appear on T+1…T+16; done=1 and busy=0 at T+17.
- Each ready-low cycle adds one cycle to this.
- A parity abort pulses done at T+1; busy stays 0.
- Throughput is one subkey per cycle. No bubbles are inserted between rounds.

## Test plan
- **Encrypt vector.** key 133457799BBCDFF1, decrypt=0, ready=1. Required: idx0 = 1B02EFFC7072, idx1 = 79AED9DBC9E5, idx15 = CB3D8B0E17F5; done at T+17, parity_err=0.
- **Decrypt order.** Same key, decrypt=1. Required: first subkey CB3D8B0E17F5 with idx 15, last 1B02EFFC7072 with idx 0. The full sequence is the exact reverse of the encrypt run.
- **Backpressure.** Encrypt run with ready low for 3 cycles at idx 1. Required: subkey 79AED9DBC9E5 and idx 1 held stable throughout; done at T+20.
- **Parity.** PARITY_CHECK=1:
  - key 133457799BBCDFF0 → done=1, parity_err=1 at T+1; subkey_valid never asserted.
  - key 133457799BBCDFF1 → normal run.
- **Reset and ignored start.** Assert rst at idx 7. Required: next cycle valid=busy=0 and subkey=0, with no done pulse. A start pulsed during RUN has no effect on the sequence.
- **Back-to-back.** start asserted in the done cycle. Required: a new schedule whose first subkey appears in the following cycle.
